mem_access_stage: RTL and testbench

Pipelined memory/writeback-select stage for the WISC core. It is the parametrised successor to the single-cycle memory stage. It drives a multi-cycle backing memory over a request/grant/response handshake and stalls the pipeline while an access is in flight. It registers the selected writeback value into the MEM/WB boundary and adds a response-timeout watchdog and a sticky error flag.

---
 rtl/mem_access_pkg.sv | 31 +++
 rtl/wb_select.sv | 39 +++
 rtl/mem_access_stage.sv | 217 +++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared types and defaults for the WISC memory/writeback-select stage.
package mem_access_pkg;

  localparam int DATA_W_DEF  = 16;
  localparam int ADDR_W_DEF  = 16;
  localparam int TIMEOUT_DEF = 64;
  localparam int IMM_W       = 8;

  typedef enum logic [2:0] {
    WB_MEM       = 3'd0,
    WB_ALU       = 3'd1,
    WB_NEXT_PC   = 3'd2,
    WB_SET_VAL   = 3'd3,
    WB_SEXT_IMM  = 3'd4,
    WB_SHIFT_IMM = 3'd5,
    WB_BITREV    = 3'd6,
    WB_INVALID   = 3'd7
  } wb_src_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

  // Watchdog counter must hold a few counts past TIMEOUT without wrapping.
  function automatic int cnt_width(input int timeout);
    return $clog2(timeout + 2);
  endfunction

endpackage

// File: rtl/wb_select.sv
// Combinational writeback source mux; flags the reserved select code.
module wb_select
  import mem_access_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [2:0]        wb_src_i,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic [DATA_W-1:0] alu_out_i,
  input  logic [DATA_W-1:0] next_pc_i,
  input  logic [DATA_W-1:0] set_val_i,
  input  logic [DATA_W-1:0] reg1_i,
  input  logic [IMM_W-1:0]  imm8_i,
  output logic [DATA_W-1:0] wb_data_o,
  output logic              invalid_o
);

  logic [DATA_W-1:0] reg1_rev;

  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_rev
    assign reg1_rev[gi] = reg1_i[DATA_W-1-gi];
  end

  always_comb begin
    wb_data_o = '0;
    invalid_o = 1'b0;
    case (wb_src_e'(wb_src_i))
      WB_MEM:       wb_data_o = mem_data_i;
      WB_ALU:       wb_data_o = alu_out_i;
      WB_NEXT_PC:   wb_data_o = next_pc_i;
      WB_SET_VAL:   wb_data_o = set_val_i;
      WB_SEXT_IMM:  wb_data_o = {{(DATA_W-IMM_W){imm8_i[IMM_W-1]}}, imm8_i};
      WB_SHIFT_IMM: wb_data_o = {reg1_i[DATA_W-IMM_W-1:0], imm8_i};
      WB_BITREV:    wb_data_o = reg1_rev;
      default:      invalid_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// WISC memory/writeback stage: multi-cycle memory handshake, registered MEM/WB output,
// response watchdog and sticky error. Define MEM_ACCESS_ALIGN_CHECK_EN to reject odd addresses.
module mem_access_stage
  import mem_access_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_mem_en,
  input  logic              in_mem_wr,
  input  logic              in_halt,
  input  logic [DATA_W-1:0] in_alu_out,
  input  logic [DATA_W-1:0] in_reg1,
  input  logic [DATA_W-1:0] in_reg2,
  input  logic [DATA_W-1:0] in_next_pc,
  input  logic [DATA_W-1:0] in_set_val,
  input  logic [DATA_W-1:0] in_instr,
  input  logic [2:0]        in_wb_src,
  input  logic              in_reg_wrt,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_dump,
  output logic              wb_valid,
  output logic              wb_reg_wrt,
  output logic [DATA_W-1:0] wb_data,
  output logic              err
);

  localparam int CNT_W = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

  state_e state_q, state_d;

  logic [CNT_W-1:0]  cnt_q;
  logic              wr_q, halt_q, reg_wrt_q;
  logic [2:0]        wb_src_q;
  logic [DATA_W-1:0] alu_q, reg1_q, reg2_q, next_pc_q, set_val_q;
  logic [IMM_W-1:0]  imm8_q;

  logic              wb_valid_q, wb_reg_wrt_q, err_q, mem_dump_q;
  logic [DATA_W-1:0] wb_data_q;
  logic              wb_reg_wrt_d, err_d, mem_dump_d;

  logic in_idle, misaligned, mem_issue, timeout_hit;
  logic wb_fire, abort, set_err, halt_sel;

  logic [2:0]        sel_src;
  logic [DATA_W-1:0] sel_mem, sel_alu, sel_npc, sel_set, sel_reg1, sel_data;
  logic [IMM_W-1:0]  sel_imm;
  logic              sel_invalid, sel_reg_wrt;

  // Only the immediate byte of the instruction word matters here.
  logic unused_instr_hi;
  assign unused_instr_hi = ^in_instr[DATA_W-1:IMM_W];

  assign in_idle     = (state_q == IDLE);
  assign timeout_hit = (cnt_q >= LIMIT);

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
  assign misaligned = in_idle & in_valid & in_mem_en & in_alu_out[0];
`else
  assign misaligned = 1'b0;
`endif

  assign mem_issue = in_idle & in_valid & in_mem_en & ~misaligned;

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (mem_issue) state_d = REQ;
      REQ: begin
        if (mem_gnt)          state_d = wr_q ? IDLE : RESP;
        else if (timeout_hit) state_d = IDLE;
      end
      RESP: if (mem_rvalid || timeout_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A handshake event on the final watchdog cycle still counts as completion.
  always_comb begin
    stall   = 1'b0;
    mem_req = 1'b0;
    mem_wr  = 1'b0;
    wb_fire = 1'b0;
    abort   = 1'b0;
    case (state_q)
      IDLE: begin
        stall   = mem_issue;
        wb_fire = in_valid & ~mem_issue;
      end
      REQ: begin
        stall   = 1'b1;
        mem_req = 1'b1;
        mem_wr  = wr_q;
        if (mem_gnt) begin
          wb_fire = wr_q;
        end else if (timeout_hit) begin
          wb_fire = 1'b1;
          abort   = 1'b1;
        end
      end
      RESP: begin
        stall = 1'b1;
        if (mem_rvalid) begin
          wb_fire = 1'b1;
        end else if (timeout_hit) begin
          wb_fire = 1'b1;
          abort   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Live inputs feed the mux in IDLE; the latched instruction feeds it otherwise.
  assign sel_src     = in_idle ? in_wb_src  : wb_src_q;
  assign sel_alu     = in_idle ? in_alu_out : alu_q;
  assign sel_npc     = in_idle ? in_next_pc : next_pc_q;
  assign sel_set     = in_idle ? in_set_val : set_val_q;
  assign sel_reg1    = in_idle ? in_reg1    : reg1_q;
  assign sel_imm     = in_idle ? in_instr[IMM_W-1:0] : imm8_q;
  assign sel_reg_wrt = in_idle ? in_reg_wrt : reg_wrt_q;
  assign halt_sel    = in_idle ? in_halt    : halt_q;
  assign sel_mem     = (state_q == RESP) ? mem_rdata : '0;

  wb_select #(
    .DATA_W (DATA_W)
  ) u_wb_select (
    .wb_src_i   (sel_src),
    .mem_data_i (sel_mem),
    .alu_out_i  (sel_alu),
    .next_pc_i  (sel_npc),
    .set_val_i  (sel_set),
    .reg1_i     (sel_reg1),
    .imm8_i     (sel_imm),
    .wb_data_o  (sel_data),
    .invalid_o  (sel_invalid)
  );

  assign set_err      = wb_fire & (sel_invalid | abort | misaligned);
  assign wb_reg_wrt_d = sel_reg_wrt & ~sel_invalid & ~abort & ~misaligned;
  assign err_d        = err_q | set_err;
  assign mem_dump_d   = (wb_fire & halt_sel) | (set_err & ~err_q);

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q        <= '0;
      wr_q         <= 1'b0;
      halt_q       <= 1'b0;
      reg_wrt_q    <= 1'b0;
      wb_src_q     <= '0;
      alu_q        <= '0;
      reg1_q       <= '0;
      reg2_q       <= '0;
      next_pc_q    <= '0;
      set_val_q    <= '0;
      imm8_q       <= '0;
      wb_valid_q   <= 1'b0;
      wb_reg_wrt_q <= 1'b0;
      wb_data_q    <= '0;
      err_q        <= 1'b0;
      mem_dump_q   <= 1'b0;
    end else begin
      if (mem_issue) begin
        wr_q      <= in_mem_wr;
        halt_q    <= in_halt;
        reg_wrt_q <= in_reg_wrt;
        wb_src_q  <= in_wb_src;
        alu_q     <= in_alu_out;
        reg1_q    <= in_reg1;
        reg2_q    <= in_reg2;
        next_pc_q <= in_next_pc;
        set_val_q <= in_set_val;
        imm8_q    <= in_instr[IMM_W-1:0];
      end
      if (mem_issue)     cnt_q <= '0;
      else if (!in_idle) cnt_q <= cnt_q + CNT_W'(1);
      wb_valid_q <= wb_fire;
      if (wb_fire) begin
        wb_data_q    <= sel_data;
        wb_reg_wrt_q <= wb_reg_wrt_d;
      end
      err_q      <= err_d;
      mem_dump_q <= mem_dump_d;
    end
  end

  if (ADDR_W <= DATA_W) begin : g_addr_trunc
    assign mem_addr = alu_q[ADDR_W-1:0];
  end else begin : g_addr_ext
    assign mem_addr = {{(ADDR_W-DATA_W){1'b0}}, alu_q};
  end

  assign mem_wdata  = reg2_q;
  assign wb_valid   = wb_valid_q;
  assign wb_reg_wrt = wb_reg_wrt_q;
  assign wb_data    = wb_data_q;
  assign err        = err_q;
  assign mem_dump   = mem_dump_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with a queue scoreboard on the writeback port.
module tb_mem_access_stage;

  localparam int DW = 16;
  localparam int AW = 16;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid, in_mem_en, in_mem_wr, in_halt, in_reg_wrt;
  logic [DW-1:0] in_alu_out, in_reg1, in_reg2, in_next_pc, in_set_val, in_instr;
  logic [2:0]    in_wb_src;
  logic          stall, mem_req, mem_wr, mem_gnt, mem_rvalid, mem_dump;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata, wb_data;
  logic          wb_valid, wb_reg_wrt, err;

  mem_access_stage #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_mem_en(in_mem_en), .in_mem_wr(in_mem_wr), .in_halt(in_halt),
    .in_alu_out(in_alu_out), .in_reg1(in_reg1), .in_reg2(in_reg2),
    .in_next_pc(in_next_pc), .in_set_val(in_set_val), .in_instr(in_instr),
    .in_wb_src(in_wb_src), .in_reg_wrt(in_reg_wrt),
    .stall(stall), .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .mem_dump(mem_dump), .wb_valid(wb_valid), .wb_reg_wrt(wb_reg_wrt), .wb_data(wb_data),
    .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          cyc;
    logic [15:0] data;
    logic        chk_data;
    logic        wrt;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic push(input int c, input logic [15:0] d, input logic cd, input logic w);
    exp_t e;
    e.cyc = c; e.data = d; e.chk_data = cd; e.wrt = w;
    sb.push_back(e);
  endtask

  // Monitor: every wb_valid pulse must match the oldest expectation, including its cycle.
  always @(negedge clk) begin
    if (wb_valid === 1'b1) begin
      $display("wb cycle %0d data %h reg_wrt %b", cyc, wb_data, wb_reg_wrt);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wb_unexpected at cycle %0d: got data %h, expected no writeback", cyc, wb_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("wb_cycle", cyc, e.cyc);
        if (e.chk_data) chk("wb_data", {16'h0, wb_data}, {16'h0, e.data});
        chk("wb_reg_wrt", {31'h0, wb_reg_wrt}, {31'h0, e.wrt});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, me, mw, h, input logic [15:0] alu, r1, r2,
                       input logic [2:0] src, input logic [15:0] ins, input logic rw);
    in_valid = v; in_mem_en = me; in_mem_wr = mw; in_halt = h;
    in_alu_out = alu; in_reg1 = r1; in_reg2 = r2; in_wb_src = src;
    in_instr = ins; in_reg_wrt = rw;
    in_next_pc = 16'h0102; in_set_val = 16'h0001;
  endtask

  task automatic idle_in();
    drive(0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 3'd0, 16'h0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ctrl"}, {25'h0, stall, mem_req, mem_wr, mem_dump, wb_valid, wb_reg_wrt, err}, 32'h0);
    chk({tag, "_addr"}, {16'h0, mem_addr}, 32'h0);
    chk({tag, "_wdata"}, {16'h0, mem_wdata}, 32'h0);
    chk({tag, "_wbdata"}, {16'h0, wb_data}, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int reqs;
    idle_in();
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 16'h0;

    // Reset state
    do_reset();
    @(negedge clk);
    chk_reset_outputs("reset");
    tick();

    // ALU op: one-cycle latency, never stalls
    drive(1, 0, 0, 0, 16'h1234, 16'h0, 16'h0, 3'd1, 16'h0, 1);
    push(cyc + 1, 16'h1234, 1, 1);
    @(negedge clk); chk("alu_stall", {31'h0, stall}, 0);
    tick(); idle_in();
    @(negedge clk); chk("alu_stall_next", {31'h0, stall}, 0);
    tick();

    // Load with gnt at once, rvalid two cycles later; second load held until IDLE
    drive(1, 1, 0, 0, 16'h0040, 16'h0, 16'h0, 3'd0, 16'h0, 1);
    @(negedge clk); chk("ld_stall0", {31'h0, stall}, 1); chk("ld_req0", {31'h0, mem_req}, 0);
    tick();
    drive(1, 1, 0, 0, 16'h0042, 16'h0, 16'h0, 3'd0, 16'h0, 1);
    mem_gnt = 1;
    @(negedge clk); chk("ld_stall1", {31'h0, stall}, 1); chk("ld_req1", {31'h0, mem_req}, 1);
    chk("ld_addr", {16'h0, mem_addr}, 32'h0040); chk("ld_wr", {31'h0, mem_wr}, 0);
    tick(); mem_gnt = 0;
    @(negedge clk); chk("ld_stall2", {31'h0, stall}, 1); chk("ld_req2", {31'h0, mem_req}, 0);
    tick(); mem_rvalid = 1; mem_rdata = 16'hBEEF; push(cyc + 1, 16'hBEEF, 1, 1);
    @(negedge clk); chk("ld_stall3", {31'h0, stall}, 1);
    tick(); mem_rvalid = 0;
    @(negedge clk); chk("ld2_accept_stall", {31'h0, stall}, 1); chk("ld2_req_wait", {31'h0, mem_req}, 0);
    tick(); idle_in();
    mem_gnt = 1; mem_rvalid = 1; mem_rdata = 16'hDEAD;
    @(negedge clk); chk("ld2_req", {31'h0, mem_req}, 1); chk("ld2_addr", {16'h0, mem_addr}, 32'h0042);
    tick(); mem_gnt = 0; mem_rvalid = 0;
    @(negedge clk); chk("ld2_resp_stall", {31'h0, stall}, 1); chk("ld2_wbv", {31'h0, wb_valid}, 0);
    tick(); mem_rvalid = 1; mem_rdata = 16'h1357; push(cyc + 1, 16'h1357, 1, 1);
    tick(); mem_rvalid = 0;
    @(negedge clk); chk("ld2_done_stall", {31'h0, stall}, 0);
    tick();

    // Minimum-latency load that is also a halt: dump after completion
    drive(1, 1, 0, 1, 16'h0060, 16'h0, 16'h0, 3'd0, 16'h0, 1);
    tick(); idle_in(); mem_gnt = 1;
    @(negedge clk); chk("hld_dump1", {31'h0, mem_dump}, 0);
    tick(); mem_gnt = 0; mem_rvalid = 1; mem_rdata = 16'h4321; push(cyc + 1, 16'h4321, 1, 1);
    @(negedge clk); chk("hld_dump2", {31'h0, mem_dump}, 0);
    tick(); mem_rvalid = 0;
    @(negedge clk); chk("hld_dump3", {31'h0, mem_dump}, 1);
    tick();
    @(negedge clk); chk("hld_dump4", {31'h0, mem_dump}, 0);
    tick();

    // Store with gnt delayed three cycles: request held stable
    drive(1, 1, 1, 0, 16'h0010, 16'h0, 16'hA5A5, 3'd1, 16'h0, 0);
    tick(); idle_in();
    for (int k = 0; k < 4; k++) begin
      if (k == 3) begin
        mem_gnt = 1;
        push(cyc + 1, 16'h0010, 1, 0);
      end
      @(negedge clk);
      chk("st_req", {31'h0, mem_req}, 1);
      chk("st_wr", {31'h0, mem_wr}, 1);
      chk("st_addr", {16'h0, mem_addr}, 32'h0010);
      chk("st_wdata", {16'h0, mem_wdata}, 32'hA5A5);
      tick();
    end
    mem_gnt = 0;
    @(negedge clk); chk("st_req_drop", {31'h0, mem_req}, 0); chk("st_stall_drop", {31'h0, stall}, 0);
    tick();

    // Non-memory halt: dump one cycle after acceptance
    drive(1, 0, 0, 1, 16'h0, 16'h0, 16'h0, 3'd2, 16'h0, 1);
    push(cyc + 1, 16'h0102, 1, 1);
    tick(); idle_in();
    @(negedge clk); chk("halt_dump", {31'h0, mem_dump}, 1);
    tick();
    @(negedge clk); chk("halt_dump_end", {31'h0, mem_dump}, 0);
    tick();

    // Immediate/bit-reverse sources, then the reserved select
    drive(1, 0, 0, 0, 16'h0, 16'h00C3, 16'h0, 3'd4, 16'h0080, 1); push(cyc + 1, 16'hFF80, 1, 1); tick();
    drive(1, 0, 0, 0, 16'h0, 16'h00C3, 16'h0, 3'd5, 16'h0080, 1); push(cyc + 1, 16'hC380, 1, 1); tick();
    drive(1, 0, 0, 0, 16'h0, 16'h00C3, 16'h0, 3'd6, 16'h0080, 1); push(cyc + 1, 16'hC300, 1, 1); tick();
    drive(1, 0, 0, 0, 16'h0, 16'h00C3, 16'h0, 3'd7, 16'h0080, 1); push(cyc + 1, 16'h0000, 0, 0);
    @(negedge clk); chk("inv_err_before", {31'h0, err}, 0);
    tick(); idle_in();
    @(negedge clk); chk("inv_err", {31'h0, err}, 1); chk("inv_dump", {31'h0, mem_dump}, 1);
    tick();
    @(negedge clk); chk("inv_err_sticky", {31'h0, err}, 1); chk("inv_dump_end", {31'h0, mem_dump}, 0);
    tick();

    do_reset();
    @(negedge clk); chk("err_cleared", {31'h0, err}, 0);
    tick();

    // rvalid on the last watchdog cycle: completion wins
    drive(1, 1, 0, 0, 16'h0070, 16'h0, 16'h0, 3'd0, 16'h0, 1);
    tick(); idle_in(); mem_gnt = 1;
    tick(); mem_gnt = 0;
    repeat (6) tick();
    mem_rvalid = 1; mem_rdata = 16'h7777; push(cyc + 1, 16'h7777, 1, 1);
    tick(); mem_rvalid = 0;
    @(negedge clk); chk("race_err", {31'h0, err}, 0); chk("race_stall", {31'h0, stall}, 0);
    tick();

    // Load never answered: abort after TIMEOUT cycles in REQ
    drive(1, 1, 0, 0, 16'h0050, 16'h0, 16'h0, 3'd0, 16'h0, 1);
    push(cyc + 9, 16'h0000, 0, 0);
    tick(); idle_in();
    reqs = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (mem_req === 1'b1) reqs++;
      if (i == 7) chk("to_err_pre", {31'h0, err}, 0);
      if (i == 8) begin
        chk("to_err", {31'h0, err}, 1);
        chk("to_dump", {31'h0, mem_dump}, 1);
      end
      tick();
    end
    chk("to_req_cycles", reqs, TO);
    chk("to_stall_after", {31'h0, stall}, 0);

    do_reset();
    tick();

    // Odd address
    drive(1, 1, 0, 0, 16'h0003, 16'h0, 16'h0, 3'd1, 16'h0, 1);
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    push(cyc + 1, 16'h0000, 0, 0);
    @(negedge clk); chk("al_stall", {31'h0, stall}, 0);
    tick(); idle_in();
    @(negedge clk); chk("al_req", {31'h0, mem_req}, 0); chk("al_err", {31'h0, err}, 1);
    tick();
`else
    push(cyc + 3, 16'h0003, 1, 1);
    @(negedge clk); chk("al_stall", {31'h0, stall}, 1);
    tick(); idle_in(); mem_gnt = 1;
    @(negedge clk); chk("al_req", {31'h0, mem_req}, 1); chk("al_addr", {16'h0, mem_addr}, 32'h0003);
    tick(); mem_gnt = 0; mem_rvalid = 1; mem_rdata = 16'h0AAA;
    tick(); mem_rvalid = 0;
    @(negedge clk); chk("al_err", {31'h0, err}, 0);
    tick();
`endif

    // Reset while in RESP; a late response is ignored
    drive(1, 1, 0, 0, 16'h0080, 16'h0, 16'h0, 3'd0, 16'h0, 1);
    tick(); idle_in(); mem_gnt = 1;
    tick(); mem_gnt = 0; rst = 1'b0;
    tick(); rst = 1'b1;
    @(negedge clk); chk_reset_outputs("midrst");
    tick(); mem_rvalid = 1; mem_rdata = 16'h9999;
    tick(); mem_rvalid = 0;
    @(negedge clk); chk("midrst_late_wbv", {31'h0, wb_valid}, 0);
    tick();
    @(negedge clk); chk("midrst_stall", {31'h0, stall}, 0);
    tick();

    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
